cc_reorder_merge_unit: RTL and testbench
========================================

# cc_reorder_merge_unit

Parametrised in-order response merger for the cache controller's read path. It sits between the memory R channel, the hit-line store, and the INCT R channel. Each read produces a hit/miss flag in request order. For a miss, the unit forwards the memory burst. For a hit, it serializes the stored cache line, starting at the critical beat and wrapping around. Unlike the previous generation, it honours `inct_rready_i` back-pressure, registers all outputs, checks burst length, and is generic in width and depth.

## Interface
- `DATA_W`, 64: beat width; power of two, ≥ 8.
- `LINE_W`, 512: cache-line width; multiple of `DATA_W`. `BEATS = LINE_W/DATA_W` (≥ 2).
- `OFS_W`, `$clog2(LINE_W/8)`: byte offset width.
- `FLAG_DEPTH`, 16: flag queue entries; power of two.
- `HIT_DEPTH`, 8: hit-line queue entries; power of two.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_rdata_i`  in  `DATA_W`  memory read beat.
- `mem_rlast_i`  in  1  last beat of memory burst.
- `mem_rvalid_i`  in  1  memory beat valid.
- `mem_rready_o`  out  1  memory beat accepted.
- `flag_wren_i`  in  1  push a flag.
- `flag_wdata_i`  in  1  flag value: 1 = hit, 0 = miss.
- `flag_afull_o`  out  1  flag queue count ≥ `FLAG_DEPTH`-1.
- `hit_wren_i`  in  1  push a hit line.
- `hit_wdata_i`  in  `OFS_W+LINE_W`  hit line: {offset, line}.
- `hit_afull_o`  out  1  hit queue count ≥ `HIT_DEPTH`-1.
- `inct_rdata_o`  out  `DATA_W`  output beat.
- `inct_rlast_o`  out  1  last beat of burst.
- `inct_rvalid_o`  out  1  output valid.
- `inct_rready_i`  in  1  output ready; may deassert at any time.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Queues.** Flag and hit queues are circular buffers with pointer wrap at depth.
  - A push to a full queue is dropped and sets `err_o`.
  - Simultaneous push and pop on a full queue is allowed. The pop frees the slot first.
- **Output register.** All `inct_*` outputs come from a one-entry output register (ORG).
  - `load = !inct_rvalid_o | inct_rready_i`.
  - Payload is held stable while `inct_rvalid_o & !inct_rready_i`.
- **State machine:** `IDLE`, `MISS`, `HIT`.
  - In `IDLE` with the flag queue non-empty, the source is chosen from the head flag in the same cycle, with no bubble. Next state is `HIT` or `MISS`.
  - `MISS`: `mem_rready_o = load`. Each accepted beat goes into the ORG with `rlast = mem_rlast_i`.
  - `HIT`: the serializer feeds the ORG when its beat is valid and `load` is high.
  - The burst ends when the source's last beat is loaded into the ORG. On that cycle the flag is popped and the state returns to `IDLE`. It may immediately select the next flag in the following cycle.
  - `mem_rready_o` is 0 whenever the current or selected source is not `MISS`. In particular, memory beats arriving during a hit, or with no flag queued, are back-pressured.
- **Hit serialization.**
  - Start beat index `s = offset[OFS_W-1:$clog2(DATA_W/8)]`.
  - Beat k (k = 0..`BEATS`-1) is `line[((s+k) mod BEATS)*DATA_W +: DATA_W]`. The beat index wraps from `BEATS`-1 to 0.
  - `rlast` is asserted on k = `BEATS`-1.
  - The hit queue is popped when beat 0 is taken. If the hit queue is empty in `HIT`, the unit waits with no output beat.
- **Miss length check.** A beat counter counts accepted miss beats.
  - If `rlast` arrives on a beat other than number `BEATS`, `err_o` is set.
  - If beat `BEATS` arrives without `rlast`, `err_o` is set.
  - The burst still ends only on `mem_rlast_i`.
- **Error flag.** `err_o` stays set until reset.

## Timing
- **Reset.** Asynchronous; takes effect immediately, including mid-burst.
  - All outputs are 0, except `mem_rready_o`, which is 0 because the flag queue is empty.
  - Queues are emptied, state is `IDLE`, counters and `err_o` are 0.
  - Partially sent bursts are discarded.
- **Latency.** A source beat accepted at edge N appears on `inct_*` after edge N. That is one cycle source-to-output, one beat per cycle sustained when `inct_rready_i` = 1.
- **Queue visibility.** A pushed entry is visible at the head the cycle after the push.
- **Almost-full flags.** `*_afull_o` are registered, derived from the count after that cycle's push and pop.

## Structure
- Shared package `cc_reorder_pkg`:
  - state enum `IDLE`/`MISS`/`HIT`;
  - default parameter constants;
  - a typedef for the hit entry struct {offset, line}.
- One sub-module, `cc_line_serializer`: it holds one line plus the start index, runs the beat counter, and uses a valid/ready handshake.
- The queues and ORG are inline.

## Test plan
- **Single miss.** Push flag 0; memory sends 8 beats 0x10..0x17 with `rlast` on 0x17 → `inct` outputs 0x10..0x17, one cycle delayed, `rlast` on 0x17; flag queue empty afterwards; `err_o` = 0.
- **Critical-beat hit.** Push flag 1 and a hit entry with offset 0x28 and beat i = 0xA0+i → output order A5, A6, A7, A0, A1, A2, A3, A4, with `rlast` on A4.
- **Reordering.** Push flags 0,1; the hit line is ready before memory → all 8 miss beats are output before any hit beat; `mem_rready_o` = 0 while the hit is serialized.
- **Back-pressure.** Toggle `inct_rready_i` 1,0,0,1 during a hit → the held beat stays stable; no beat is lost or duplicated; 8 beats total.
- **Protocol error.** `rlast` arrives on the 6th miss beat → burst ends after 6 beats; `err_o` = 1 and stays set.
- **Reset and full.** Push 16 flags → `flag_afull_o` = 1 after the 15th push; the 17th push sets `err_o`; asserting `rst` mid-burst → outputs 0 the same cycle, and the queues read empty.

Source files
------------

// File: rtl/cc_reorder_pkg.sv
// Shared types and default sizes for the read-path reorder/merge unit.
package cc_reorder_pkg;

  localparam int DATA_W_DEF     = 64;
  localparam int LINE_W_DEF     = 512;
  localparam int OFS_W_DEF      = $clog2(LINE_W_DEF / 8);
  localparam int FLAG_DEPTH_DEF = 16;
  localparam int HIT_DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    HIT  = 2'd2
  } state_e;

  // Hit entry as presented on hit_wdata_i for the default geometry.
  typedef struct packed {
    logic [OFS_W_DEF-1:0]  offset;
    logic [LINE_W_DEF-1:0] line;
  } hit_entry_t;

endpackage

// File: rtl/cc_reorder_merge_unit_serializer.sv
// Serialises one cache line into beats, starting at the critical beat and
// wrapping. Beat 0 is taken straight from the input so there is no bubble;
// the line is captured on that handshake for the remaining beats.
module cc_line_serializer
  import cc_reorder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  localparam int BEATS = LINE_W / DATA_W,
  localparam int IW    = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  input  logic [IW-1:0]     start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] beat_o,
  output logic              last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam logic [IW:0]   BEATS_X  = (IW+1)'(BEATS);
  localparam logic [IW-1:0] LAST_CNT = IW'(BEATS - 1);

  logic [LINE_W-1:0] line_q, line_d;
  logic [IW-1:0]     start_q, start_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0] line_sel;
  logic [IW-1:0]     start_sel;
  logic [IW:0]       sum;
  logic [IW-1:0]     idx;
  logic              first;
  logic              take;
  logic [DATA_W-1:0] beats [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_beat
    assign beats[g] = line_sel[g*DATA_W +: DATA_W];
  end

  // Beat selection, handshake and beat-counter next state.
  always_comb begin
    first       = (cnt_q == '0);
    line_sel    = first ? line_i : line_q;
    start_sel   = first ? start_i : start_q;
    sum         = {1'b0, start_sel} + {1'b0, cnt_q};
    idx         = (sum >= BEATS_X) ? IW'(sum - BEATS_X) : sum[IW-1:0];
    beat_o      = beats[idx];
    last_o      = (cnt_q == LAST_CNT);
    out_valid_o = first ? in_valid_i : 1'b1;
    in_ready_o  = first & out_ready_i;
    take        = out_valid_o & out_ready_i;
    cnt_d       = cnt_q;
    line_d      = line_q;
    start_d     = start_q;
    if (take) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
      if (first) begin
        line_d  = line_i;
        start_d = start_i;
      end
    end
  end

  // Held line, start index and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q  <= '0;
      start_q <= '0;
      cnt_q   <= '0;
    end else begin
      line_q  <= line_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cc_reorder_merge_unit.sv
// In-order read response merger: forwards memory bursts for misses and
// serialised stored lines for hits, in flag order, through a registered
// output stage that honours inct_rready_i.
module cc_reorder_merge_unit
  import cc_reorder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int OFS_W      = $clog2(LINE_W / 8),
  parameter int FLAG_DEPTH = FLAG_DEPTH_DEF,
  parameter int HIT_DEPTH  = HIT_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_rready_o,
  input  logic                    flag_wren_i,
  input  logic                    flag_wdata_i,
  output logic                    flag_afull_o,
  input  logic                    hit_wren_i,
  input  logic [OFS_W+LINE_W-1:0] hit_wdata_i,
  output logic                    hit_afull_o,
  output logic [DATA_W-1:0]       inct_rdata_o,
  output logic                    inct_rlast_o,
  output logic                    inct_rvalid_o,
  input  logic                    inct_rready_i,
  output logic                    err_o
);

  localparam int BEATS = LINE_W / DATA_W;
  localparam int SW    = $clog2(BEATS);
  localparam int LSB   = $clog2(DATA_W / 8);
  localparam int FPW   = $clog2(FLAG_DEPTH);
  localparam int FCW   = FPW + 1;
  localparam int HPW   = $clog2(HIT_DEPTH);
  localparam int HCW   = HPW + 1;
  localparam int MCW   = SW + 2;
  localparam int HE_W  = SW + LINE_W;
  localparam logic [FCW-1:0] FLAG_FULL  = FCW'(FLAG_DEPTH);
  localparam logic [FCW-1:0] FLAG_AFULL = FCW'(FLAG_DEPTH - 1);
  localparam logic [HCW-1:0] HIT_FULL   = HCW'(HIT_DEPTH);
  localparam logic [HCW-1:0] HIT_AFULL  = HCW'(HIT_DEPTH - 1);
  localparam logic [MCW-1:0] BEATS_M    = MCW'(BEATS);

  logic             flag_mem_q [FLAG_DEPTH];
  logic [HE_W-1:0]  hit_mem_q  [HIT_DEPTH];
  logic [FPW-1:0]   flag_wr_q, flag_wr_d, flag_rd_q, flag_rd_d;
  logic [FCW-1:0]   flag_cnt_q, flag_cnt_d;
  logic [HPW-1:0]   hit_wr_q, hit_wr_d, hit_rd_q, hit_rd_d;
  logic [HCW-1:0]   hit_cnt_q, hit_cnt_d;
  logic             flag_afull_q, flag_afull_d, hit_afull_q, hit_afull_d;
  logic [DATA_W-1:0] org_data_q, org_data_d;
  logic             org_last_q, org_last_d, org_valid_q, org_valid_d;
  state_e           state_q, state_d, src;
  logic             err_q, err_d;
  logic [MCW-1:0]   miss_cnt_q, miss_cnt_d, miss_n;
  logic             load, flag_empty, flag_full, hit_empty, hit_full;
  logic             flag_push, flag_pop, hit_push, hit_pop;
  logic             miss_take, hit_take, burst_end;
  logic             ser_in_ready, ser_valid, ser_out_ready, ser_last;
  logic [DATA_W-1:0] ser_beat;
  logic [HE_W-1:0]  hit_head;
  logic             unused_ok;

  // Only the beat-index bits of the offset matter; the byte bits are dropped.
  assign unused_ok = ^hit_wdata_i;
  assign hit_head  = hit_mem_q[hit_rd_q];

  cc_line_serializer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .line_i      (hit_head[LINE_W-1:0]),
    .start_i     (hit_head[HE_W-1 -: SW]),
    .in_valid_i  (!hit_empty),
    .in_ready_o  (ser_in_ready),
    .beat_o      (ser_beat),
    .last_o      (ser_last),
    .out_valid_o (ser_valid),
    .out_ready_i (ser_out_ready)
  );

  // Source selection, output register, queue bookkeeping and error tracking.
  always_comb begin
    load       = !org_valid_q | inct_rready_i;
    flag_empty = (flag_cnt_q == '0);
    flag_full  = (flag_cnt_q == FLAG_FULL);
    hit_empty  = (hit_cnt_q == '0);
    hit_full   = (hit_cnt_q == HIT_FULL);
    src        = state_q;
    if (state_q == IDLE && !flag_empty) begin
      src = flag_mem_q[flag_rd_q] ? HIT : MISS;
    end
    mem_rready_o  = (src == MISS) & load;
    ser_out_ready = (src == HIT) & load;
    miss_take     = mem_rvalid_i & mem_rready_o;
    hit_take      = ser_valid & ser_out_ready;
    burst_end     = (miss_take & mem_rlast_i) | (hit_take & ser_last);
    state_d       = burst_end ? IDLE : src;

    org_data_d  = org_data_q;
    org_last_d  = org_last_q;
    org_valid_d = org_valid_q;
    if (load) begin
      org_valid_d = miss_take | hit_take;
      if (miss_take) begin
        org_data_d = mem_rdata_i;
        org_last_d = mem_rlast_i;
      end else if (hit_take) begin
        org_data_d = ser_beat;
        org_last_d = ser_last;
      end
    end

    flag_pop  = burst_end;
    flag_push = flag_wren_i & (!flag_full | flag_pop);
    hit_pop   = ser_in_ready & !hit_empty;
    hit_push  = hit_wren_i & (!hit_full | hit_pop);
    flag_wr_d  = flag_push ? flag_wr_q + 1'b1 : flag_wr_q;
    flag_rd_d  = flag_pop ? flag_rd_q + 1'b1 : flag_rd_q;
    flag_cnt_d = flag_cnt_q + FCW'(flag_push) - FCW'(flag_pop);
    hit_wr_d   = hit_push ? hit_wr_q + 1'b1 : hit_wr_q;
    hit_rd_d   = hit_pop ? hit_rd_q + 1'b1 : hit_rd_q;
    hit_cnt_d  = hit_cnt_q + HCW'(hit_push) - HCW'(hit_pop);
    flag_afull_d = (flag_cnt_d >= FLAG_AFULL);
    hit_afull_d  = (hit_cnt_d >= HIT_AFULL);

    err_d      = err_q | (flag_wren_i & !flag_push) | (hit_wren_i & !hit_push);
    miss_n     = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
    miss_cnt_d = miss_cnt_q;
    if (miss_take) begin
      if (mem_rlast_i) begin
        err_d      = err_d | (miss_n != BEATS_M);
        miss_cnt_d = '0;
      end else begin
        err_d      = err_d | (miss_n == BEATS_M);
        miss_cnt_d = miss_n;
      end
    end
  end

  // Queue storage; contents are don't-care while the counts say empty.
  always_ff @(posedge clk) begin
    if (flag_push) flag_mem_q[flag_wr_q] <= flag_wdata_i;
    if (hit_push)  hit_mem_q[hit_wr_q]   <= {hit_wdata_i[LINE_W+LSB +: SW], hit_wdata_i[LINE_W-1:0]};
  end

  // Control state, pointers, output register and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flag_wr_q    <= '0;
      flag_rd_q    <= '0;
      flag_cnt_q   <= '0;
      hit_wr_q     <= '0;
      hit_rd_q     <= '0;
      hit_cnt_q    <= '0;
      flag_afull_q <= 1'b0;
      hit_afull_q  <= 1'b0;
      org_data_q   <= '0;
      org_last_q   <= 1'b0;
      org_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      flag_wr_q    <= flag_wr_d;
      flag_rd_q    <= flag_rd_d;
      flag_cnt_q   <= flag_cnt_d;
      hit_wr_q     <= hit_wr_d;
      hit_rd_q     <= hit_rd_d;
      hit_cnt_q    <= hit_cnt_d;
      flag_afull_q <= flag_afull_d;
      hit_afull_q  <= hit_afull_d;
      org_data_q   <= org_data_d;
      org_last_q   <= org_last_d;
      org_valid_q  <= org_valid_d;
      err_q        <= err_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign inct_rdata_o  = org_data_q;
  assign inct_rlast_o  = org_last_q;
  assign inct_rvalid_o = org_valid_q;
  assign flag_afull_o  = flag_afull_q;
  assign hit_afull_o   = hit_afull_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cc_reorder_merge_unit.sv
// Directed bench with a scoreboard: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted output beat.
module tb_cc_reorder_merge_unit;
  import cc_reorder_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic [63:0]    mem_rdata_i;
  logic           mem_rlast_i, mem_rvalid_i, mem_rready_o;
  logic           flag_wren_i, flag_wdata_i, flag_afull_o;
  logic           hit_wren_i, hit_afull_o;
  logic [517:0]   hit_wdata_i;
  logic [63:0]    inct_rdata_o;
  logic           inct_rlast_o, inct_rvalid_o, inct_rready_i, err_o;

  typedef struct packed { logic [63:0] d; logic l; } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [63:0] held_d;
  logic        held_l;
  logic        held_v = 1'b0;
  logic [63:0] crit_exp [8] = '{64'hA5, 64'hA6, 64'hA7, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4};
  logic        bp_pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  cc_reorder_merge_unit dut (
    .clk(clk), .rst(rst),
    .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .flag_wren_i(flag_wren_i), .flag_wdata_i(flag_wdata_i), .flag_afull_o(flag_afull_o),
    .hit_wren_i(hit_wren_i), .hit_wdata_i(hit_wdata_i), .hit_afull_o(hit_afull_o),
    .inct_rdata_o(inct_rdata_o), .inct_rlast_o(inct_rlast_o),
    .inct_rvalid_o(inct_rvalid_o), .inct_rready_i(inct_rready_i), .err_o(err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: held-beat stability and in-order scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && inct_rvalid_o) begin
        check("held_data", inct_rdata_o, held_d);
        check("held_last", inct_rlast_o, held_l);
      end
      held_v = inct_rvalid_o && !inct_rready_i;
      held_d = inct_rdata_o;
      held_l = inct_rlast_o;
      if (inct_rvalid_o && inct_rready_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %0h with nothing expected", inct_rdata_o);
        end else begin
          mon_e = sb.pop_front();
          if (inct_rdata_o !== mon_e.d || inct_rlast_o !== mon_e.l) begin
            bad++;
            $display("FAIL beat: got %0h last=%0b expected %0h last=%0b",
                     inct_rdata_o, inct_rlast_o, mon_e.d, mon_e.l);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flag(input logic f);
    flag_wren_i  = 1'b1;
    flag_wdata_i = f;
    tick();
    flag_wren_i  = 1'b0;
  endtask

  function automatic logic [517:0] make_hit(input logic [5:0] ofs, input logic [63:0] base);
    hit_entry_t e;
    e.offset = ofs;
    for (int i = 0; i < 8; i++) e.line[i*64 +: 64] = base + 64'(i);
    return e;
  endfunction

  task automatic exp_miss(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{d: base + 64'(i), l: (i == n-1)});
  endtask

  task automatic exp_hit(input logic [63:0] base, input logic [5:0] ofs);
    int s;
    s = int'(ofs[5:3]);
    for (int k = 0; k < 8; k++) sb.push_back('{d: base + 64'((s + k) % 8), l: (k == 7)});
  endtask

  task automatic mem_send(input logic [63:0] base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   cyc;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + 64'(i);
      mem_rlast_i  = (i == last_idx);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = mem_rready_o;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL mem_accept_timeout: beat %0d not taken, required acceptance", i);
      end else begin
        check("miss_latency_valid", inct_rvalid_o, 1);
        check("miss_latency_data", inct_rdata_o, base + 64'(i));
      end
    end
    mem_rvalid_i = 1'b0;
    mem_rlast_i  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_rdata_i = '0; mem_rlast_i = 1'b0; mem_rvalid_i = 1'b0;
    flag_wren_i = 1'b0; flag_wdata_i = 1'b0;
    hit_wren_i = 1'b0; hit_wdata_i = '0;
    inct_rready_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_rvalid", inct_rvalid_o, 0);
    check("rst_rdata", inct_rdata_o, 0);
    check("rst_rlast", inct_rlast_o, 0);
    check("rst_mem_rready", mem_rready_o, 0);
    check("rst_err", err_o, 0);
    check("rst_flag_afull", flag_afull_o, 0);
    check("rst_hit_afull", hit_afull_o, 0);

    // Single miss
    push_flag(1'b0);
    exp_miss(64'h10, 8);
    mem_send(64'h10, 8, 7);
    wait_drain("single_miss_drain");
    check("single_miss_err", err_o, 0);
    check("single_miss_rready_idle", mem_rready_o, 0);

    // Critical-beat hit: offset 0x28 -> start beat 5
    flag_wren_i = 1'b1; flag_wdata_i = 1'b1;
    hit_wren_i  = 1'b1; hit_wdata_i = make_hit(6'h28, 64'hA0);
    for (int k = 0; k < 8; k++) sb.push_back('{d: crit_exp[k], l: (k == 7)});
    tick();
    flag_wren_i = 1'b0; hit_wren_i = 1'b0;
    wait_drain("crit_hit_drain");

    // Reordering: miss then hit, hit line available first
    push_flag(1'b0);
    exp_miss(64'h20, 8);
    push_flag(1'b1);
    exp_hit(64'hB0, 6'h10);
    hit_wren_i = 1'b1; hit_wdata_i = make_hit(6'h10, 64'hB0);
    tick();
    hit_wren_i = 1'b0;
    repeat (4) tick();
    mem_send(64'h20, 8, 7);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("reorder_mem_rready_during_hit", mem_rready_o, 0);
      @(posedge clk);
      #1;
    end
    mem_rvalid_i = 1'b0;
    wait_drain("reorder_drain");

    // Back-pressure during a hit
    flag_wren_i = 1'b1; flag_wdata_i = 1'b1;
    hit_wren_i  = 1'b1; hit_wdata_i = make_hit(6'h38, 64'hC0);
    exp_hit(64'hC0, 6'h38);
    tick();
    flag_wren_i = 1'b0; hit_wren_i = 1'b0;
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      inct_rready_i = bp_pat[c % 4];
      tick();
    end
    inct_rready_i = 1'b1;
    wait_drain("backpressure_drain");
    check("backpressure_err", err_o, 0);

    // Protocol error: rlast on 6th beat
    push_flag(1'b0);
    exp_miss(64'h30, 6);
    mem_send(64'h30, 6, 5);
    wait_drain("short_burst_drain");
    check("short_burst_err", err_o, 1);
    repeat (5) tick();
    check("short_burst_err_sticky", err_o, 1);

    // Reset, fill flag queue, overflow, reset mid-burst
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    check("rerst_err", err_o, 0);
    for (int i = 1; i <= 16; i++) begin
      push_flag(1'b0);
      if (i == 14) check("afull_after_14", flag_afull_o, 0);
      if (i == 15) check("afull_after_15", flag_afull_o, 1);
    end
    check("full_no_err", err_o, 0);
    push_flag(1'b0);
    check("overflow_err", err_o, 1);
    for (int i = 0; i < 3; i++) sb.push_back('{d: 64'h40 + 64'(i), l: 1'b0});
    mem_send(64'h40, 3, -1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_rvalid", inct_rvalid_o, 0);
    check("midrst_rdata", inct_rdata_o, 0);
    check("midrst_rlast", inct_rlast_o, 0);
    check("midrst_mem_rready", mem_rready_o, 0);
    check("midrst_err", err_o, 0);
    check("midrst_flag_afull", flag_afull_o, 0);
    tick();
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBEEF;
    @(negedge clk);
    check("postrst_flag_q_empty", mem_rready_o, 0);
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    push_flag(1'b1);
    for (int c = 0; c < 5; c++) begin
      check("postrst_hit_q_empty", inct_rvalid_o, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
